// File: rtl/flash_ctrl_pkg.sv
// Shared flash-controller constants.
//   RdFifoDepth : entry count of the read-data FIFO
//   BusW        : flash bus word width
package flash_ctrl_pkg;

    localparam int RdFifoDepth = 16;
    localparam int BusW        = 32;

endpackage

// File: rtl/flash_rd_fifo_if.sv
// Write/read handshake bundle of the flash read-data FIFO.
//   wr_i / wdata_i / wrdy_o     : producer side (read controller data_wr / data / data_rdy)
//   rvalid_o / rready_i / rdata_o : consumer side (host read path)
// Signal suffixes are from the FIFO's point of view.
//   slave  : the FIFO
//   master : the producer/consumer pair driving it
interface flash_rd_fifo_if #(
    parameter int DataW = flash_ctrl_pkg::BusW
);

    logic             wr_i;
    logic [DataW-1:0] wdata_i;
    logic             wrdy_o;
    logic             rvalid_o;
    logic             rready_i;
    logic [DataW-1:0] rdata_o;

    modport slave (
        input  wr_i, wdata_i, rready_i,
        output wrdy_o, rvalid_o, rdata_o
    );

    modport master (
        output wr_i, wdata_i, rready_i,
        input  wrdy_o, rvalid_o, rdata_o
    );

endinterface

// File: rtl/flash_fifo_ptr.sv
// Wrap-bit pointer pair for a power-of-two FIFO.
// It is shared by the read-data and program-data FIFOs.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clr            : synchronous flush, which returns both pointers to 0
//   wr_en, rd_en   : already-qualified push/pop, which advance the pointers
//   widx, ridx     : storage indices (pointer bits without the wrap bit)
//   full, empty    : decoded from the registered pointers
//   level          : registered fill level, which tracks the pointer registers
//   level_next     : the fill level the next clock edge will load
module flash_fifo_ptr
    import flash_ctrl_pkg::*;
#(
    parameter  int Depth = RdFifoDepth,
    localparam int IdxW  = $clog2(Depth),
    localparam int PtrW  = IdxW + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr,
    input  logic            wr_en,
    input  logic            rd_en,
    output logic [IdxW-1:0] widx,
    output logic [IdxW-1:0] ridx,
    output logic            full,
    output logic            empty,
    output logic [PtrW-1:0] level,
    output logic [PtrW-1:0] level_next
);

    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [PtrW-1:0] wptr_d, rptr_d;

    // NOTE: every signal driven here gets a default on entry, so no path can leave it unassigned and infer a latch.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_en) wptr_d = wptr_q + PtrW'(1);
            if (rd_en) rptr_d = rptr_q + PtrW'(1);
        end
    end

    // The pointers are one bit wider than the index. Modulo subtraction therefore yields 0..Depth without ambiguity.
    assign level_next = wptr_d - rptr_d;

    // NOTE: state registers use non-blocking assignment, so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            level  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            level  <= level_next;
        end
    end

    assign widx  = wptr_q[IdxW-1:0];
    assign ridx  = rptr_q[IdxW-1:0];
    assign empty = (wptr_q == rptr_q);
    assign full  = (widx == ridx) && (wptr_q[IdxW] != rptr_q[IdxW]);

endmodule

// File: rtl/flash_rd_fifo.sv
// Read-data buffer between the flash read controller and the host read path.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous flush; empties the FIFO and clears ovfl_err_o
//   bus (slave)   : wr_i/wdata_i/wrdy_o from the controller;
//                   rvalid_o/rready_i/rdata_o to the consumer (fall-through head)
//   depth_o       : registered fill level, 0..Depth
//   wmark_i       : watermark threshold
//   wmark_o       : registered flag, level >= wmark_i
//   ovfl_err_o    : sticky flag, set when a write is attempted while the FIFO is full
module flash_rd_fifo
    import flash_ctrl_pkg::*;
#(
    parameter  int DataW  = BusW,
    parameter  int Depth  = RdFifoDepth,
    localparam int DepthW = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    flash_rd_fifo_if.slave    bus,
    output logic [DepthW-1:0] depth_o,
    input  logic [DepthW-1:0] wmark_i,
    output logic              wmark_o,
    output logic              ovfl_err_o
);

    localparam int IdxW = $clog2(Depth);

    logic              full, empty;
    logic              wr_en, rd_en;
    logic [IdxW-1:0]   widx, ridx;
    logic [DepthW-1:0] level_next;

    // A flush overrides any concurrent push or pop.
    assign wr_en = bus.wr_i & ~full & ~clr_i;
    assign rd_en = ~empty & bus.rready_i & ~clr_i;

    flash_fifo_ptr #(
        .Depth (Depth)
    ) u_ptr (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr        (clr_i),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .widx       (widx),
        .ridx       (ridx),
        .full       (full),
        .empty      (empty),
        .level      (depth_o),
        .level_next (level_next)
    );

    logic [DataW-1:0] mem [Depth];

    // NOTE: the storage array has no reset. Empty slots are never visible because rdata_o is gated by empty.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[widx] <= bus.wdata_i;
    end

    assign bus.wrdy_o   = ~full;
    assign bus.rvalid_o = ~empty;
    assign bus.rdata_o  = empty ? '0 : mem[ridx];

    // The watermark flag compares against the level being loaded this edge, so it updates together with depth_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wmark_o    <= 1'b0;
            ovfl_err_o <= 1'b0;
        end else begin
            wmark_o <= (level_next >= wmark_i);
            if (clr_i) begin
                ovfl_err_o <= 1'b0;
            end else if (bus.wr_i && full) begin
                ovfl_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flash_rd_fifo.sv
// Self-checking bench for flash_rd_fifo at Depth = 4.
// A queue-based reference model predicts every output in every cycle.
// Directed steps follow each scenario, with a randomized stretch in between.
module tb_flash_rd_fifo;
    import flash_ctrl_pkg::*;

    localparam int Depth  = 4;
    localparam int DataW  = BusW;
    localparam int DepthW = $clog2(Depth + 1);

    logic              clk_i  = 1'b0;
    logic              rst_ni = 1'b0;
    logic              clr_i  = 1'b0;
    logic [DepthW-1:0] depth_o;
    logic [DepthW-1:0] wmark_i = DepthW'(3);
    logic              wmark_o;
    logic              ovfl_err_o;

    flash_rd_fifo_if #(.DataW(DataW)) bus ();

    flash_rd_fifo #(
        .DataW (DataW),
        .Depth (Depth)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (clr_i),
        .bus        (bus),
        .depth_o    (depth_o),
        .wmark_i    (wmark_i),
        .wmark_o    (wmark_o),
        .ovfl_err_o (ovfl_err_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model: contents in arrival order, plus the two flags.
    logic [DataW-1:0] q[$];
    logic             m_ovfl  = 1'b0;
    logic             m_wmark = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] head;
        head = (q.size() != 0) ? q[0] : 32'h0;
        check({tag, ".rvalid"}, 32'(bus.rvalid_o), 32'(q.size() != 0));
        check({tag, ".rdata"},  bus.rdata_o,       head);
        check({tag, ".wrdy"},   32'(bus.wrdy_o),   32'(q.size() < Depth));
        check({tag, ".depth"},  32'(depth_o),      32'(q.size()));
        check({tag, ".wmark"},  32'(wmark_o),      32'(m_wmark));
        check({tag, ".ovfl"},   32'(ovfl_err_o),   32'(m_ovfl));
    endtask

    // Apply the effect of one clock edge to the model.
    task automatic model_edge(input logic wr, input logic [DataW-1:0] d, input logic rdy, input logic clr);
        int n;
        n = q.size();
        if (clr) begin
            q.delete();
            m_ovfl = 1'b0;
        end else begin
            if (rdy && n != 0) void'(q.pop_front());
            if (wr) begin
                if (n < Depth) q.push_back(d);
                else           m_ovfl = 1'b1;
            end
        end
        m_wmark = (q.size() >= int'(wmark_i));
    endtask

    // Drive one cycle: set the inputs, check the current outputs, take the edge, update the model.
    task automatic drive(input logic wr, input logic [DataW-1:0] d, input logic rdy, input logic clr);
        bus.wr_i     = wr;
        bus.wdata_i  = d;
        bus.rready_i = rdy;
        clr_i        = clr;
        #1;
        check_all("cyc");
        @(posedge clk_i);
        model_edge(wr, d, rdy, clr);
        #1;
    endtask

    initial begin
        bus.wr_i     = 1'b0;
        bus.wdata_i  = '0;
        bus.rready_i = 1'b0;

        // Reset values.
        #3;
        check("rst.rvalid", 32'(bus.rvalid_o), 32'd0);
        check("rst.wrdy",   32'(bus.wrdy_o),   32'd1);
        check("rst.depth",  32'(depth_o),      32'd0);
        check("rst.wmark",  32'(wmark_o),      32'd0);
        check("rst.ovfl",   32'(ovfl_err_o),   32'd0);
        check("rst.rdata",  bus.rdata_o,       32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Fill: four writes with no reads.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
            check("fill.depth", 32'(depth_o), 32'(i + 1));
            if (i == 0) check("fill.rvalid_rise", 32'(bus.rvalid_o), 32'd1);
        end
        check("fill.wrdy_low", 32'(bus.wrdy_o), 32'd0);
        check("fill.head",     bus.rdata_o,     32'hA0);

        // Overflow while full.
        drive(1'b1, 32'hFF, 1'b0, 1'b0);
        check("ovfl.flag",  32'(ovfl_err_o), 32'd1);
        check("ovfl.depth", 32'(depth_o),    32'd4);

        // Drain in order; 0xFF must never appear.
        for (int i = 0; i < 4; i++) begin
            check("drain.data", bus.rdata_o, 32'hA0 + 32'(i));
            drive(1'b0, '0, 1'b1, 1'b0);
        end
        check("drain.rvalid", 32'(bus.rvalid_o), 32'd0);

        // Streaming across pointer wrap, 1 word pre-filled.
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) begin
            check("stream.depth", 32'(depth_o),  32'd1);
            check("stream.data",  bus.rdata_o,   32'h100 + 32'(i - 1));
            drive(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
        end
        check("stream.last", bus.rdata_o, 32'h109);
        drive(1'b0, '0, 1'b1, 1'b0);
        check("stream.ovfl",  32'(ovfl_err_o),   32'd0);
        check("stream.empty", 32'(bus.rvalid_o), 32'd0);

        // Flush with a concurrent write at depth 3 with the overflow flag set.
        for (int i = 0; i < 5; i++) drive(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        check("pre_clr.depth", 32'(depth_o),    32'd3);
        check("pre_clr.ovfl",  32'(ovfl_err_o), 32'd1);
        drive(1'b1, 32'hDEAD, 1'b0, 1'b1);
        check("clr.depth",  32'(depth_o),      32'd0);
        check("clr.rvalid", 32'(bus.rvalid_o), 32'd0);
        check("clr.ovfl",   32'(ovfl_err_o),   32'd0);
        check("clr.wrdy",   32'(bus.wrdy_o),   32'd1);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("clr.dropped", 32'(bus.rvalid_o), 32'd0);

        // Watermark at threshold 2, then at threshold 0.
        wmark_i = DepthW'(2);
        drive(1'b1, 32'h51, 1'b0, 1'b0);
        check("wm.one",  32'(wmark_o), 32'd0);
        drive(1'b1, 32'h52, 1'b0, 1'b0);
        check("wm.two",  32'(wmark_o), 32'd1);
        drive(1'b0, '0, 1'b1, 1'b0);
        check("wm.back", 32'(wmark_o), 32'd0);
        drive(1'b0, '0, 1'b1, 1'b0);
        wmark_i = DepthW'(0);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("wm.zero_empty", 32'(wmark_o),      32'd1);
        check("wm.zero_rv",    32'(bus.rvalid_o), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) wmark_i = DepthW'($urandom_range(0, Depth));
            drive(logic'($urandom_range(0, 99) < 60), DataW'($urandom),
                  logic'($urandom_range(0, 99) < 50), logic'($urandom_range(0, 39) == 0));
        end

        // Asynchronous reset mid-stream at depth 2.
        wmark_i = DepthW'(3);
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b1, 32'hE0, 1'b0, 1'b0);
        drive(1'b1, 32'hE1, 1'b0, 1'b0);
        check("arst.pre_depth", 32'(depth_o), 32'd2);
        bus.wr_i     = 1'b1;
        bus.wdata_i  = 32'hE2;
        bus.rready_i = 1'b1;
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst.rvalid", 32'(bus.rvalid_o), 32'd0);
        check("arst.depth",  32'(depth_o),      32'd0);
        check("arst.wrdy",   32'(bus.wrdy_o),   32'd1);
        check("arst.rdata",  bus.rdata_o,       32'd0);
        q.delete();
        m_ovfl  = 1'b0;
        m_wmark = 1'b0;
        @(posedge clk_i);
        #1;
        check("arst.hold_rvalid", 32'(bus.rvalid_o), 32'd0);
        @(negedge clk_i);
        bus.wr_i     = 1'b0;
        bus.rready_i = 1'b0;
        rst_ni       = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        check("arst.no_stale", 32'(bus.rvalid_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
